// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
// Returns result, ROB index and destination preg as a registered one-cycle writeback pulse.
`default_nettype none

module div_unit #(
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [2:0]           funct3,
    input  logic [31:0]          rs1_v,
    input  logic [31:0]          rs2_v,
    input  logic [ROB_IDX_W-1:0] rob_idx,
    input  logic [PREG_W-1:0]    pd,
    output logic                 wb_valid,
    output logic [ROB_IDX_W-1:0] wb_rob_idx,
    output logic [PREG_W-1:0]    wb_pd,
    output logic [31:0]          wb_rd_v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [4:0]             cnt;
    logic [32:0]            rem_r;
    logic [31:0]            quo_r;
    logic [31:0]            dsr;
    logic                   q_neg;
    logic                   r_neg;
    logic                   is_rem;
    logic [ROB_IDX_W-1:0]   tag_rob;
    logic [PREG_W-1:0]      tag_pd;

    logic        accept;
    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        div_zero;
    logic        ovf;
    logic [31:0] fast_res;
    logic [32:0] r_sh;
    logic        ge;
    logic [32:0] r_nx;
    logic [31:0] q_nx;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] calc_res;
    logic        unused_funct3;

    assign unused_funct3 = funct3[2];

    assign issue_ready = (state == IDLE) && !flush;
    assign accept      = issue_valid && issue_ready;

    // funct3[0] = unsigned, funct3[1] = remainder
    assign sign1    = !funct3[0] && rs1_v[31];
    assign sign2    = !funct3[0] && rs2_v[31];
    assign mag1     = sign1 ? (32'd0 - rs1_v) : rs1_v;
    assign mag2     = sign2 ? (32'd0 - rs2_v) : rs2_v;
    assign div_zero = (rs2_v == 32'd0);
    assign ovf      = !funct3[0] && (rs1_v == 32'h8000_0000) && (rs2_v == 32'hFFFF_FFFF);

    always_comb begin
        fast_res = 32'd0;
        if (div_zero) begin
            fast_res = funct3[1] ? rs1_v : 32'hFFFF_FFFF;
        end else begin
            fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; the final step's outputs feed the sign-corrected result directly.
    assign r_sh     = {rem_r[31:0], quo_r[31]};
    assign ge       = (r_sh >= {1'b0, dsr});
    assign r_nx     = ge ? (r_sh - {1'b0, dsr}) : r_sh;
    assign q_nx     = {quo_r[30:0], ge};
    assign q_fin    = q_neg ? (32'd0 - q_nx) : q_nx;
    assign r_fin    = r_neg ? (32'd0 - r_nx[31:0]) : r_nx[31:0];
    assign calc_res = is_rem ? r_fin : q_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            rem_r      <= 33'd0;
            quo_r      <= 32'd0;
            dsr        <= 32'd0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            is_rem     <= 1'b0;
            tag_rob    <= '0;
            tag_pd     <= '0;
            wb_valid   <= 1'b0;
            wb_rob_idx <= '0;
            wb_pd      <= '0;
            wb_rd_v    <= 32'd0;
        end else begin
            wb_valid   <= 1'b0;
            wb_rob_idx <= '0;
            wb_pd      <= '0;
            wb_rd_v    <= 32'd0;
            if (flush) begin
                state <= IDLE;
                cnt   <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            tag_rob <= rob_idx;
                            tag_pd  <= pd;
                            is_rem  <= funct3[1];
                            q_neg   <= sign1 ^ sign2;
                            r_neg   <= sign1;
                            if (div_zero || ovf) begin
                                state      <= DONE;
                                wb_valid   <= 1'b1;
                                wb_rob_idx <= rob_idx;
                                wb_pd      <= pd;
                                wb_rd_v    <= fast_res;
                            end else begin
                                state <= CALC;
                                cnt   <= 5'd0;
                                rem_r <= 33'd0;
                                quo_r <= mag1;
                                dsr   <= mag2;
                            end
                        end
                    end
                    CALC: begin
                        rem_r <= r_nx;
                        quo_r <= q_nx;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state      <= DONE;
                            wb_valid   <= 1'b1;
                            wb_rob_idx <= tag_rob;
                            wb_pd      <= tag_pd;
                            wb_rd_v    <= calc_res;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
